uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- 8N1 UART receiver; the counterpart of the team's UART sender (idle-high line, LSB first, one stop bit).
- Samples the asynchronous serial input at 16x the baud rate, using a tick divided down from sysclk.
- Validates the start bit, shifts in 8 data bits and checks the stop bit.
- Presents each received byte with a one-cycle strobe, and flags framing errors.

Parameters:
- OVERSAMPLE_DIV, 651: sysclk cycles per 16x oversample tick. 100 MHz / (9600 × 16), rounded. Legal range 1 to 65535.

Ports:
- sysclk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- UART_RXD  in  1  serial input, asynchronous to sysclk, idle high.
- RX_DATA  out  8  last correctly framed byte; held until the next good frame.
- RX_STATUS  out  1  one-sysclk pulse when RX_DATA is updated.
- RX_ERR  out  1  one-sysclk pulse when a frame has a stop bit of 0.

Behaviour:
- Reset (asynchronous, active-high):
  - State IDLE; all counters cleared.
  - Synchronizer flops set to 1.
  - RX_DATA = 0x00, RX_STATUS = 0, RX_ERR = 0.
  - Reset asserted mid-frame discards the partial byte; no strobe is issued.
- Synchronizer:
  - Two-flop synchronizer on UART_RXD produces rxd_s.
  - All decisions use rxd_s only; this adds 2 sysclk cycles of input latency.
- Tick generator:
  - Free-running counter 0 to OVERSAMPLE_DIV-1.
  - tick is high for one cycle when the counter wraps.
  - Runs in every state and is never restarted by frame events.
  - Start-edge detection jitter is therefore at most 1 tick (1/16 bit).
- Sample counter: scnt, 4 bits, advances only on tick. Bit index: bidx, 3 bits.
- IDLE:
  - On a tick with rxd_s = 0, go to START with scnt = 0.
- START (start-bit validation):
  - scnt increments on each tick.
  - On the tick where scnt = 7 (mid start bit):
    - rxd_s = 0: go to DATA with scnt = 0, bidx = 0.
    - rxd_s = 1: glitch; return to IDLE, no output.
- DATA:
  - scnt increments on each tick.
  - On the tick where scnt = 15 (centre of each bit):
    - Shift register bit[bidx] is loaded from rxd_s, LSB first.
    - scnt resets to 0; bidx increments.
  - After bidx = 7 is sampled, go to STOP.
- STOP:
  - On the tick where scnt = 15, sample rxd_s.
  - rxd_s = 1:
    - RX_DATA is loaded from the shift register.
    - RX_STATUS goes high in the following cycle for exactly 1 sysclk.
    - Go to IDLE.
  - rxd_s = 0:
    - RX_ERR goes high for exactly 1 sysclk; RX_DATA is unchanged.
    - Go to BREAK.
- BREAK:
  - Wait for rxd_s = 1, sampled on a tick, then go to IDLE.
  - A line held low (break) produces only the single RX_ERR pulse.
- Back-to-back frames:
  - The stop sample is taken at mid stop bit, so IDLE is re-entered about half a bit early.
  - A start bit immediately after the stop bit is therefore detected with no idle gap required.
- Latency: the RX_STATUS pulse occurs 9.5 bit times (152 ticks) ± 1 tick after the start falling edge, plus 2–3 sysclk.
- Outputs: RX_STATUS and RX_ERR are never high together. There is no handshake; the consumer must capture RX_DATA on the pulse or before the next frame completes.
- Tolerance: correct reception with a baud mismatch of up to ±3%.

Test Plan:
- Benches use OVERSAMPLE_DIV = 4, giving 1 bit = 64 sysclk.
- Test 1, single frame: send 0x55 8N1 at nominal rate.
  - RX_DATA = 0x55.
  - One single-cycle RX_STATUS pulse, 608 ± 8 sysclk after the start edge.
  - RX_ERR stays 0.
- Test 2, back-to-back: send 0xA3 immediately followed by 0x0F, with no idle gap.
  - Two RX_STATUS pulses, with RX_DATA = 0xA3 then 0x0F.
  - Pulses 640 ± 4 cycles apart.
- Test 3, start glitch: drive a 12-cycle low pulse, then idle for 2 bit times, then send 0x81.
  - No output for the glitch.
  - Exactly one pulse afterwards, with RX_DATA = 0x81.
- Test 4, framing error and break: after a good 0x3C, send 0xFF with a stop bit of 0 and hold the line low for 20 bit times. Release the line, then send 0x96.
  - For the errored frame: a single RX_ERR pulse, no RX_STATUS, RX_DATA stays 0x3C.
  - After release: RX_DATA = 0x96 with one RX_STATUS pulse.
- Test 5, reset mid-frame: assert reset during data bit 4 of 0xC7 for 10 cycles.
  - Immediately: RX_DATA = 0x00, both strobes 0, no pulse for the aborted frame.
  - A later 0x5A is received correctly.
- Test 6, rate tolerance: send 0x6B at a bit period of 62 cycles, then again at 66 cycles (−3% / +3%).
  - Both frames received as 0x6B, with RX_ERR staying 0.

Source files
------------

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 16x oversampling from a free-running tick, start-bit validation,
// LSB-first data capture, stop-bit check with one-cycle data/error strobes.
module uart_receiver #(
  parameter int unsigned OVERSAMPLE_DIV = 651
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       UART_RXD,
  output logic [7:0] RX_DATA,
  output logic       RX_STATUS,
  output logic       RX_ERR
);

  localparam logic [15:0] TickMax = 16'(OVERSAMPLE_DIV - 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StStart = 3'd1;
  localparam logic [2:0] StData  = 3'd2;
  localparam logic [2:0] StStop  = 3'd3;
  localparam logic [2:0] StBreak = 3'd4;

  logic [1:0]  sync_q;
  logic        rxd_s;
  logic [15:0] tick_cnt_q;
  logic        tick;

  logic [2:0] state_q, state_d;
  logic [3:0] scnt_q, scnt_d;
  logic [2:0] bidx_q, bidx_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] data_q, data_d;
  logic       status_q, status_d;
  logic       err_q, err_d;

  assign rxd_s = sync_q[1];
  assign tick  = (tick_cnt_q == TickMax);

  // Synchronizer resets to idle-high so reset release never looks like a start edge.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      sync_q     <= 2'b11;
      tick_cnt_q <= '0;
    end else begin
      sync_q     <= {sync_q[0], UART_RXD};
      tick_cnt_q <= tick ? 16'd0 : tick_cnt_q + 16'd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    scnt_d   = scnt_q;
    bidx_d   = bidx_q;
    shreg_d  = shreg_q;
    data_d   = data_q;
    status_d = 1'b0;
    err_d    = 1'b0;
    if (tick) begin
      case (state_q)
        StIdle: begin
          if (!rxd_s) begin
            state_d = StStart;
            scnt_d  = 4'd0;
          end
        end
        StStart: begin
          if (scnt_q == 4'd7) begin
            scnt_d = 4'd0;
            bidx_d = 3'd0;
            state_d = rxd_s ? StIdle : StData;
          end else begin
            scnt_d = scnt_q + 4'd1;
          end
        end
        StData: begin
          if (scnt_q == 4'd15) begin
            shreg_d[bidx_q] = rxd_s;
            scnt_d          = 4'd0;
            bidx_d          = bidx_q + 3'd1;
            if (bidx_q == 3'd7) state_d = StStop;
          end else begin
            scnt_d = scnt_q + 4'd1;
          end
        end
        StStop: begin
          // Sampled mid stop bit, so a following start edge is caught with no idle gap.
          if (scnt_q == 4'd15) begin
            scnt_d = 4'd0;
            if (rxd_s) begin
              data_d   = shreg_q;
              status_d = 1'b1;
              state_d  = StIdle;
            end else begin
              err_d   = 1'b1;
              state_d = StBreak;
            end
          end else begin
            scnt_d = scnt_q + 4'd1;
          end
        end
        StBreak: begin
          if (rxd_s) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      scnt_q   <= '0;
      bidx_q   <= '0;
      shreg_q  <= '0;
      data_q   <= '0;
      status_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      scnt_q   <= scnt_d;
      bidx_q   <= bidx_d;
      shreg_q  <= shreg_d;
      data_q   <= data_d;
      status_q <= status_d;
      err_q    <= err_d;
    end
  end

  assign RX_DATA   = data_q;
  assign RX_STATUS = status_q;
  assign RX_ERR    = err_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: table of single frames plus hand-written
// back-to-back, start-glitch and mid-frame reset sequences.
module tb_uart_receiver;

  localparam int unsigned Div = 4;
  localparam int Bit = 64;

  logic       sysclk = 1'b0;
  logic       reset = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] rx_data;
  logic       rx_status;
  logic       rx_err;

  uart_receiver #(.OVERSAMPLE_DIV(Div)) dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .UART_RXD (rxd),
    .RX_DATA  (rx_data),
    .RX_STATUS(rx_status),
    .RX_ERR   (rx_err)
  );

  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  // Pulse monitor: logs every data strobe and counts errors, wide pulses and overlaps.
  int         stat_cyc[$];
  logic [7:0] stat_data[$];
  int   err_cnt = 0, wide_cnt = 0, both_cnt = 0;
  logic prev_stat = 1'b0, prev_err = 1'b0;
  always @(negedge sysclk) begin
    if (rx_status) begin
      stat_cyc.push_back(cyc);
      stat_data.push_back(rx_data);
    end
    if (rx_err) err_cnt <= err_cnt + 1;
    if ((rx_status && prev_stat) || (rx_err && prev_err)) wide_cnt <= wide_cnt + 1;
    if (rx_status && rx_err) both_cnt <= both_cnt + 1;
    prev_stat <= rx_status;
    prev_err  <= rx_err;
  end

  int passed = 0, total = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    total++;
    if (act >= lo && act <= hi) passed++;
    else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
  endtask

  task automatic drive(input logic v, input int n);
    rxd = v;
    repeat (n) @(negedge sysclk);
  endtask

  // Called on a negedge; t0 is the cycle count at the start falling edge.
  task automatic send(input logic [7:0] d, input int per, input logic stop, output int t0);
    t0 = cyc;
    drive(1'b0, per);
    for (int i = 0; i < 8; i++) drive(d[i], per);
    drive(stop, per);
  endtask

  typedef struct {
    logic [7:0] data;
    int         per;
    logic       stop;
    int         hold;
    logic [7:0] exp_data;
    bit         exp_status;
    bit         exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n0, e0, t0, t1;
    logic [7:0] abort_byte;

    vecs[0] = '{8'h55, 64, 1'b1, 0,  8'h55, 1'b1, 1'b0};
    vecs[1] = '{8'h6B, 62, 1'b1, 0,  8'h6B, 1'b1, 1'b0};
    vecs[2] = '{8'h6B, 66, 1'b1, 0,  8'h6B, 1'b1, 1'b0};
    vecs[3] = '{8'h3C, 64, 1'b1, 0,  8'h3C, 1'b1, 1'b0};
    vecs[4] = '{8'hFF, 64, 1'b0, 20, 8'h3C, 1'b0, 1'b1};
    vecs[5] = '{8'h96, 64, 1'b1, 0,  8'h96, 1'b1, 1'b0};

    reset = 1'b1;
    rxd   = 1'b1;
    repeat (3) @(negedge sysclk);
    check("reset_data", int'(rx_data), 0);
    check("reset_status", int'(rx_status), 0);
    check("reset_err", int'(rx_err), 0);
    reset = 1'b0;
    drive(1'b1, 2 * Bit);

    for (int i = 0; i < 6; i++) begin
      n0 = stat_cyc.size();
      e0 = err_cnt;
      send(vecs[i].data, vecs[i].per, vecs[i].stop, t0);
      if (vecs[i].hold > 0) drive(1'b0, vecs[i].hold * vecs[i].per);
      drive(1'b1, 2 * Bit);
      check($sformatf("vec%0d_status_pulses", i), stat_cyc.size() - n0, int'(vecs[i].exp_status));
      check($sformatf("vec%0d_err_pulses", i), err_cnt - e0, int'(vecs[i].exp_err));
      check($sformatf("vec%0d_rx_data", i), int'(rx_data), int'(vecs[i].exp_data));
      if (vecs[i].exp_status && stat_cyc.size() == n0 + 1) begin
        check_rng($sformatf("vec%0d_latency", i), stat_cyc[n0] - t0, 600, 616);
        check($sformatf("vec%0d_data_at_pulse", i), int'(stat_data[n0]), int'(vecs[i].data));
      end
    end

    // Back-to-back frames with no idle gap.
    n0 = stat_cyc.size();
    e0 = err_cnt;
    send(8'hA3, Bit, 1'b1, t0);
    send(8'h0F, Bit, 1'b1, t1);
    drive(1'b1, 2 * Bit);
    check("b2b_pulses", stat_cyc.size() - n0, 2);
    check("b2b_err", err_cnt - e0, 0);
    if (stat_cyc.size() == n0 + 2) begin
      check("b2b_first", int'(stat_data[n0]), 8'hA3);
      check("b2b_second", int'(stat_data[n0 + 1]), 8'h0F);
      check_rng("b2b_spacing", stat_cyc[n0 + 1] - stat_cyc[n0], 636, 644);
    end

    // Short low glitch must be rejected at start-bit validation.
    n0 = stat_cyc.size();
    e0 = err_cnt;
    drive(1'b0, 12);
    drive(1'b1, 2 * Bit);
    check("glitch_pulses", stat_cyc.size() - n0, 0);
    check("glitch_err", err_cnt - e0, 0);
    send(8'h81, Bit, 1'b1, t0);
    drive(1'b1, 2 * Bit);
    check("post_glitch_pulses", stat_cyc.size() - n0, 1);
    check("post_glitch_data", int'(rx_data), 8'h81);

    // Reset during data bit 4; the sender aborts too, leaving the line idle.
    abort_byte = 8'hC7;
    n0 = stat_cyc.size();
    e0 = err_cnt;
    drive(1'b0, Bit);
    for (int i = 0; i < 4; i++) drive(abort_byte[i], Bit);
    drive(abort_byte[4], 20);
    reset = 1'b1;
    rxd   = 1'b1;
    #1;
    check("midreset_data", int'(rx_data), 0);
    check("midreset_status", int'(rx_status), 0);
    check("midreset_err", int'(rx_err), 0);
    repeat (10) @(negedge sysclk);
    reset = 1'b0;
    drive(1'b1, 4 * Bit);
    check("aborted_pulses", stat_cyc.size() - n0, 0);
    check("aborted_err", err_cnt - e0, 0);
    send(8'h5A, Bit, 1'b1, t0);
    drive(1'b1, 2 * Bit);
    check("post_reset_pulses", stat_cyc.size() - n0, 1);
    check("post_reset_data", int'(rx_data), 8'h5A);
    check("post_reset_err", err_cnt - e0, 0);

    check("wide_pulses", wide_cnt, 0);
    check("status_err_overlap", both_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
